// File: rtl/audio_pkg.sv
// Shared audio-path types and frame geometry for the I2S output stage.
// A frame is two 32-bit slots (left, right) and is addressed by a 6-bit bit counter.
package audio_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } drv_state_t;

endpackage

// File: rtl/i2s_timing.sv
// I2S bit-clock generator: divides clk into bclk, counts bits within the frame and
// drives lrclk, exposing the bclk falling-edge strobe and the frame boundary strobe.
module i2s_timing
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             bclk,
    output logic             lrclk,
    output logic             fall,
    output logic             frame_boundary,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int                DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             wrap;

    // bit_cnt and lrclk advance together on the falling bclk edge, so the new word
    // select and the new data bit leave the block in the same cycle.
    always_comb begin
        wrap           = (div_q == DIV_LAST);
        div_d          = wrap ? '0 : div_q + 1'b1;
        bclk_d         = wrap ? ~bclk_q : bclk_q;
        fall           = wrap && bclk_q;
        bit_cnt_d      = fall ? bit_cnt_q + 1'b1 : bit_cnt_q;
        lrclk_d        = fall ? bit_cnt_d[CNT_W-1] : lrclk_q;
        frame_boundary = fall && (bit_cnt_q == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            bclk_q    <= 1'b1;
            lrclk_q   <= 1'b1;
            bit_cnt_q <= '1;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_frame_driver.sv
// Frame-rate master for the synth chain: requests one sample per frame, captures it,
// and sends it as 24-bit I2S on both slots, resending the last sample on a missed deadline.
module i2s_frame_driver #(
    parameter int BCLK_HALF = 8,
    parameter int SAMPLE_W  = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                start,
    input  logic                finish,
    input  logic [SAMPLE_W-1:0] wave_in,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun
);

    import audio_pkg::*;

    logic             fall;
    logic             frame_boundary;
    logic [CNT_W-1:0] bit_cnt;

    drv_state_t          state_q, state_d;
    logic [SAMPLE_W-1:0] pending_q, pending_d;
    logic                pending_valid_q, pending_valid_d;
    logic [SAMPLE_W-1:0] tx_sample_q, tx_sample_d;
    logic                sdata_q, sdata_d;
    logic                start_q, start_d;
    logic                underrun_q, underrun_d;
    logic                first_q, first_d;

    logic [SLOT_BITS-1:0]  slot_word;
    logic [FRAME_BITS-1:0] frame_word;
    logic [CNT_W-1:0]      next_cnt;
    logic                  capture;

    i2s_timing #(
        .BCLK_HALF(BCLK_HALF)
    ) u_timing (
        .clk            (clk),
        .rst_n          (rst_n),
        .bclk           (i2s_bclk),
        .lrclk          (i2s_lrclk),
        .fall           (fall),
        .frame_boundary (frame_boundary),
        .bit_cnt        (bit_cnt)
    );

    // Slot layout: bit 0 is the one-bclk I2S delay, then the sample MSB first, then zero
    // padding. Indexing the doubled slot with ~next_cnt yields frame bit next_cnt directly.
    always_comb begin
        slot_word                        = '0;
        slot_word[SLOT_BITS-2 -: SAMPLE_W] = tx_sample_q;
        frame_word                       = {slot_word, slot_word};
        next_cnt                         = bit_cnt + 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        tx_sample_d     = tx_sample_q;
        sdata_d         = sdata_q;
        start_d         = 1'b0;
        underrun_d      = 1'b0;
        first_d         = first_q;
        capture         = (state_q == WAIT) && finish;

        if (fall) begin
            sdata_d = frame_word[~next_cnt];
        end

        if (frame_boundary) begin
            first_d = 1'b0;
            if (pending_valid_q) begin
                tx_sample_d     = pending_q;
                pending_valid_d = 1'b0;
            end else if (!first_q) begin
                underrun_d = 1'b1;
            end
            if (state_q == WAIT) begin
                underrun_d = 1'b1;
            end else begin
                start_d = 1'b1;
                state_d = WAIT;
            end
        end

        // A capture landing on a boundary still wins; its sample waits one more frame.
        if (capture) begin
            pending_d       = wave_in;
            pending_valid_d = 1'b1;
            state_d         = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            tx_sample_q     <= '0;
            sdata_q         <= 1'b0;
            start_q         <= 1'b0;
            underrun_q      <= 1'b0;
            first_q         <= 1'b1;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            tx_sample_q     <= tx_sample_d;
            sdata_q         <= sdata_d;
            start_q         <= start_d;
            underrun_q      <= underrun_d;
            first_q         <= first_d;
        end
    end

    assign start     = start_q;
    assign underrun  = underrun_q;
    assign i2s_sdata = sdata_q;

endmodule

// File: tb/tb_i2s_frame_driver.sv
// Directed bench for i2s_frame_driver with BCLK_HALF=2 (256 clk cycles per frame):
// drives the synth handshake by hand and checks strobes and every serialized frame.
module tb_i2s_frame_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        finish = 1'b0;
    logic [23:0] wave_in = '0;
    logic        start;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;

    int errors = 0;
    int checks = 0;
    int startTotal = 0;
    int underrunTotal = 0;

    logic [63:0] frameQ[$];
    logic [63:0] lrQ[$];

    always #5 clk = ~clk;

    i2s_frame_driver #(
        .BCLK_HALF (2),
        .SAMPLE_W  (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .finish    (finish),
        .wave_in   (wave_in),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Waits delayCycles negedges, then presents one finish pulse with the given sample.
    task automatic applyStimulus(input int delayCycles, input logic [23:0] value);
        repeat (delayCycles) @(negedge clk);
        finish  = 1'b1;
        wave_in = value;
        @(negedge clk);
        finish  = 1'b0;
        wave_in = '0;
    endtask

    task automatic waitBoundary(input string tag);
        logic prevLr;
        bit   seen;
        prevLr = i2s_lrclk;
        seen   = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (prevLr && !i2s_lrclk) seen = 1'b1;
            prevLr = i2s_lrclk;
        end
        if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic checkBoundary(input string tag, input logic expStart, input logic expUnder);
        checkOutput({tag, "_start"}, start, expStart);
        checkOutput({tag, "_underrun"}, underrun, expUnder);
    endtask

    // Frame monitor: samples sdata/lrclk on each bclk rise, a frame closes on lrclk falling.
    initial begin
        logic [63:0] curBits;
        logic [63:0] curLr;
        int          bitIdx;
        logic        prevBclk;
        logic        prevLr;
        curBits  = '0;
        curLr    = '0;
        bitIdx   = 0;
        prevBclk = 1'b1;
        prevLr   = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bitIdx   = 0;
                prevBclk = 1'b1;
                prevLr   = 1'b1;
            end else begin
                if (start) startTotal++;
                if (underrun) underrunTotal++;
                if (prevLr && !i2s_lrclk) begin
                    if (bitIdx == 64) begin
                        frameQ.push_back(curBits);
                        lrQ.push_back(curLr);
                    end
                    bitIdx = 0;
                end
                if (!prevBclk && i2s_bclk) begin
                    curBits = {curBits[62:0], i2s_sdata};
                    curLr   = {curLr[62:0], i2s_lrclk};
                    bitIdx++;
                end
                prevBclk = i2s_bclk;
                prevLr   = i2s_lrclk;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] heldVals[5];
        logic [23:0] expS[8];
        logic [31:0] slotExp;

        heldVals = '{24'h0F0F0F, 24'h111111, 24'h222222, 24'h333333, 24'h444444};
        expS     = '{24'h000000, 24'hA5F00F, 24'hA5F00F, 24'h123456,
                     24'h0F0F0F, 24'h800000, 24'h800000, 24'h5A5A5A};

        repeat (3) @(negedge clk);
        checkOutput("rst_bclk", i2s_bclk, 1);
        checkOutput("rst_lrclk", i2s_lrclk, 1);
        checkOutput("rst_sdata", i2s_sdata, 0);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_underrun", underrun, 0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("start_cycle1", start, 0);
        @(negedge clk);
        checkOutput("start_cycle2", start, 1);
        checkOutput("first_underrun", underrun, 0);
        checkOutput("b0_lrclk", i2s_lrclk, 0);
        @(negedge clk);
        checkOutput("start_width", start, 0);

        applyStimulus(9, 24'hA5F00F);
        waitBoundary("b1");
        checkBoundary("b1", 1, 0);
        checkOutput("b1_sdata", i2s_sdata, 0);

        waitBoundary("b2");
        checkBoundary("b2", 0, 1);
        applyStimulus(10, 24'h123456);
        applyStimulus(5, 24'h777777);

        waitBoundary("b3");
        checkBoundary("b3", 1, 0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            finish  = 1'b1;
            wave_in = heldVals[i];
            @(negedge clk);
        end
        finish  = 1'b0;
        wave_in = '0;

        waitBoundary("b4");
        checkBoundary("b4", 1, 0);
        applyStimulus(10, 24'h800000);

        waitBoundary("b5");
        checkBoundary("b5", 1, 0);
        repeat (255) @(negedge clk);
        finish  = 1'b1;
        wave_in = 24'h5A5A5A;
        @(negedge clk);
        finish  = 1'b0;
        wave_in = '0;
        checkOutput("b6_lrclk", i2s_lrclk, 0);
        checkBoundary("b6", 0, 1);

        waitBoundary("b7");
        checkBoundary("b7", 1, 0);
        applyStimulus(10, 24'h010000);

        waitBoundary("b8");
        checkBoundary("b8", 1, 0);
        repeat (161) @(negedge clk);
        checkOutput("pre_rst_sdata", i2s_sdata, 1);
        checkOutput("pre_rst_bclk", i2s_bclk, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_bclk", i2s_bclk, 1);
        checkOutput("async_lrclk", i2s_lrclk, 1);
        checkOutput("async_sdata", i2s_sdata, 0);
        checkOutput("async_start", start, 0);
        checkOutput("async_underrun", underrun, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rerst_cycle1", start, 0);
        @(negedge clk);
        checkOutput("rerst_start", start, 1);
        checkOutput("rerst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        checkOutput("start_total", startTotal, 8);
        checkOutput("underrun_total", underrunTotal, 2);

        checkOutput("frame_count_ok", frameQ.size() >= 8, 1);
        for (int i = 0; i < 8 && i < frameQ.size(); i++) begin
            slotExp = {1'b0, expS[i], 7'd0};
            checkOutput($sformatf("frame%0d_data", i), frameQ[i], {slotExp, slotExp});
            checkOutput($sformatf("frame%0d_lrclk", i), lrQ[i], 64'h00000000_FFFFFFFF);
        end
        if (frameQ.size() > 5) begin
            checkOutput("msb_only_frame", frameQ[5], 64'h40000000_40000000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
